// File: rtl/cmos_dvp_pattern_tx.sv
// Synthetic DVP camera source: RGB565 test frames as byte pairs with vsync/href timing.
// Optional CRC-16/CCITT over active bytes when DVP_TX_CRC_EN is defined.
module cmos_dvp_pattern_tx #(
   parameter int H_ACTIVE    = 1024,
   parameter int H_BLANK     = 256,
   parameter int V_ACTIVE    = 768,
   parameter int VSYNC_LINES = 4,
   parameter int V_BACK      = 16,
   parameter int V_FRONT     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       dvp_vsync,
   output logic       dvp_href,
   output logic [7:0] dvp_data,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic [15:0] frame_crc
);

   localparam int L    = 2 * H_ACTIVE + H_BLANK;
   localparam int CW   = $clog2(L);
   localparam int XW   = $clog2(H_ACTIVE);
   localparam int M1   = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
   localparam int M2   = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
   localparam int VMAX = (M1 > M2) ? M1 : M2;
   localparam int LW   = $clog2(VMAX + 1);

   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

   state_t          state, nstate;
   logic [CW-1:0]   col, ncol;
   logic [LW-1:0]   line, nline, last;
   logic [1:0]      pat;
   logic [15:0]     xx, yy, pix, bar_rgb;
   logic [2:0]      bar;
   logic [7:0]      byte_n;
   logic            href_n, done_n, frame_start;

   // Next raster position; outputs are registered from it so they line up with state.
   always_comb begin
      nstate = state;
      ncol   = col;
      nline  = line;
      unique case (state)
         VSYNC:   last = LW'(VSYNC_LINES - 1);
         VBACK:   last = LW'(V_BACK - 1);
         ACTIVE:  last = LW'(V_ACTIVE - 1);
         VFRONT:  last = LW'(V_FRONT - 1);
         default: last = '0;
      endcase
      if (state == IDLE) begin
         if (enable) begin
            nstate = VSYNC;
            ncol   = '0;
            nline  = '0;
         end
      end else if (col != CW'(L - 1)) begin
         ncol = col + 1'b1;
      end else begin
         ncol = '0;
         if (line != last) begin
            nline = line + 1'b1;
         end else begin
            nline = '0;
            unique case (state)
               VSYNC:   nstate = VBACK;
               VBACK:   nstate = ACTIVE;
               ACTIVE:  nstate = VFRONT;
               VFRONT:  nstate = enable ? VSYNC : IDLE;
               default: nstate = IDLE;
            endcase
         end
      end
   end

   always_comb begin
      xx  = 16'(ncol >> 1);
      yy  = 16'(nline);
      bar = 3'(xx >> (XW - 3));
      unique case (bar)
         3'd0: bar_rgb = 16'hFFFF;
         3'd1: bar_rgb = 16'hFFE0;
         3'd2: bar_rgb = 16'h07FF;
         3'd3: bar_rgb = 16'h07E0;
         3'd4: bar_rgb = 16'hF81F;
         3'd5: bar_rgb = 16'hF800;
         3'd6: bar_rgb = 16'h001F;
         3'd7: bar_rgb = 16'h0000;
      endcase
      unique case (pat)
         2'd0: pix = bar_rgb;
         2'd1: pix = {xx[4:0], xx[5:0], xx[4:0]};
         2'd2: pix = (xx[5] ^ yy[5]) ? 16'hFFFF : 16'h0000;
         2'd3: pix = {frame_cnt[4:0], 6'd0, ~frame_cnt[4:0]};
      endcase
      byte_n      = ncol[0] ? pix[7:0] : pix[15:8];
      href_n      = (nstate == ACTIVE) && (ncol < CW'(2 * H_ACTIVE));
      done_n      = (nstate == VFRONT) && (nline == LW'(V_FRONT - 1))
                    && (ncol == CW'(L - 1));
      frame_start = (nstate == VSYNC) && (state != VSYNC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         line       <= '0;
         pat        <= '0;
         dvp_vsync  <= 1'b0;
         dvp_href   <= 1'b0;
         dvp_data   <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= nstate;
         col        <= ncol;
         line       <= nline;
         dvp_vsync  <= (nstate == VSYNC);
         dvp_href   <= href_n;
         dvp_data   <= href_n ? byte_n : 8'h00;
         frame_done <= done_n;
         if (done_n)
            frame_cnt <= frame_cnt + 1'b1;
         if (frame_start)
            pat <= pattern_sel;
      end
   end

`ifdef DVP_TX_CRC_EN
   logic [15:0] crc;

   function automatic logic [15:0] crc_step(input logic [15:0] c,
                                            input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   // Absorbs each byte the cycle after it is on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc       <= 16'hFFFF;
         frame_crc <= '0;
      end else begin
         if (frame_start)
            crc <= 16'hFFFF;
         else if (dvp_href)
            crc <= crc_step(crc, dvp_data);
         if (done_n)
            frame_crc <= crc;
      end
   end
`else
   assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_cmos_dvp_pattern_tx.sv
// Scoreboard bench for cmos_dvp_pattern_tx on the small-timing build.
// Reference frames are built from pattern rules; a negedge monitor checks timing and bytes.
module tb_cmos_dvp_pattern_tx;

   localparam int HA = 8;
   localparam int HB = 4;
   localparam int VA = 4;
   localparam int VS = 1;
   localparam int VB = 1;
   localparam int VF = 1;
   localparam int L  = 2 * HA + HB;
   localparam int FR = (VS + VB + VA + VF) * L;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [1:0] pattern_sel;
   logic       dvp_vsync;
   logic       dvp_href;
   logic [7:0] dvp_data;
   logic       frame_done;
   logic [7:0] frame_cnt;
   logic [15:0] frame_crc;

   cmos_dvp_pattern_tx #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
      .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .pattern_sel(pattern_sel), .dvp_vsync(dvp_vsync),
      .dvp_href(dvp_href), .dvp_data(dvp_data),
      .frame_done(frame_done), .frame_cnt(frame_cnt),
      .frame_crc(frame_crc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int off; int d; } byte_t;
   typedef struct { int off; int cnt; int crc; } done_t;

   byte_t q_byte[$];
   done_t q_done[$];
   int    q_rise[$];

   int n_vec = 0;
   int n_err = 0;
   int fc    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int pix(input int p, input int x, input int y,
                              input int f);
      int bars[8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0,
                      'hF81F, 'hF800, 'h001F, 'h0000};
      case (p)
         0: return bars[x / (HA / 8)];
         1: return ((x % 32) << 11) | ((x % 64) << 5) | (x % 32);
         2: return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 'hFFFF : 0;
         default: return ((f % 32) << 11) | (31 - (f % 32));
      endcase
   endfunction

   function automatic int crc_b(input int c0, input int d);
      int c;
      c = c0 ^ (d << 8);
      for (int i = 0; i < 8; i++)
         c = ((c & 'h8000) != 0) ? (((c << 1) ^ 'h1021) & 'hFFFF)
                                 : ((c << 1) & 'hFFFF);
      return c;
   endfunction

   task automatic push_frame(input int p, input int rise);
      int c, v, off;
      c = 'hFFFF;
      q_rise.push_back(rise);
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++) begin
            v   = pix(p, x, y, fc);
            off = (VS + VB) * L + y * L + 2 * x;
            q_byte.push_back('{off, v >> 8});
            q_byte.push_back('{off + 1, v & 'hFF});
            c = crc_b(c, v >> 8);
            c = crc_b(c, v & 'hFF);
         end
      fc = (fc + 1) % 256;
`ifndef DVP_TX_CRC_EN
      c = 0;
`endif
      q_done.push_back('{FR - 1, fc, c});
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
      #1;
   endtask

   // n back-to-back frames; enable dropped 10 clocks into the last one.
   task automatic run(input int n, input int p[3]);
      int k, rise;
      pattern_sel = 2'(p[0]);
      @(negedge clk);
      #1;
      enable = 1'b1;
      k = cyc;
      for (int i = 0; i < n; i++)
         push_frame(p[i], k + 1 + FR * i);
      for (int i = 0; i < n; i++) begin
         rise = k + 1 + FR * i;
         if (i < n - 1) begin
            wait_until(rise + 50);
            pattern_sel = 2'(p[i + 1]);
         end else begin
            wait_until(rise + 10);
            enable = 1'b0;
            pattern_sel = 2'($urandom);
         end
      end
      wait_until(k + 1 + FR * n + 60);
   endtask

   logic  vs_q = 1'b0;
   int    last_rise = 0;
   byte_t eb;
   done_t ed;

   always @(negedge clk) begin
      if (!rst_n) begin
         vs_q = 1'b0;
      end else begin
         if (dvp_vsync && !vs_q) begin
            if (q_rise.size() == 0)
               chk("vsync_rise_unexpected", cyc, -1);
            else
               chk("vsync_rise", cyc, q_rise.pop_front());
            last_rise = cyc;
         end
         if (!dvp_vsync && vs_q)
            chk("vsync_width", cyc - last_rise, VS * L);
         if (dvp_href) begin
            if (q_byte.size() == 0) begin
               chk("href_unexpected", cyc - last_rise, -1);
            end else begin
               eb = q_byte.pop_front();
               chk("href_offset", cyc - last_rise, eb.off);
               chk("data", int'(dvp_data), eb.d);
            end
         end else begin
            chk("blank_data", int'(dvp_data), 0);
         end
         if (frame_done) begin
            if (q_done.size() == 0) begin
               chk("done_unexpected", cyc - last_rise, -1);
            end else begin
               ed = q_done.pop_front();
               chk("done_offset", cyc - last_rise, ed.off);
               chk("frame_cnt", int'(frame_cnt), ed.cnt);
               chk("frame_crc", int'(frame_crc), ed.crc);
            end
         end
         vs_q = dvp_vsync;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_vsync"}, int'(dvp_vsync), 0);
      chk({tag, "_href"}, int'(dvp_href), 0);
      chk({tag, "_data"}, int'(dvp_data), 0);
      chk({tag, "_done"}, int'(frame_done), 0);
      chk({tag, "_cnt"}, int'(frame_cnt), 0);
      chk({tag, "_crc"}, int'(frame_crc), 0);
   endtask

   initial begin
      int p[3];
      int k;
      rst_n = 1'b0;
      enable = 1'b0;
      pattern_sel = 2'd0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;

      // bars, then checker selected mid-frame, enable dropped in frame 2
      run(3, '{0, 2, 2});

      // reset asserted during ACTIVE
      pattern_sel = 2'($urandom);
      @(negedge clk);
      #1;
      enable = 1'b1;
      k = cyc;
      push_frame(int'(pattern_sel), k + 1);
      wait_until(k + 1 + (VS + VB) * L + 5);
      rst_n = 1'b0;
      enable = 1'b0;
      q_byte.delete();
      q_done.delete();
      q_rise.delete();
      fc = 0;
      @(negedge clk);
      #1;
      chk_zero("mid_reset");
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      p = '{$urandom_range(0, 3), 0, 0};
      run(1, p);

      // solid colour with frame_cnt 1 then 2
      run(2, '{3, 3, 0});

      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 3; j++)
            p[j] = $urandom_range(0, 3);
         run($urandom_range(1, 3), p);
      end

      chk("pending_bytes", q_byte.size(), 0);
      chk("pending_done", q_done.size(), 0);
      chk("pending_rise", q_rise.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
